interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter SOURCES, default 8, number of external interrupt sources (legal 1..31; IDs 1..SOURCES, ID 0 = none).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 irq_src  input  SOURCES  asynchronous interrupt lines; bit i-1 is source ID i.
REQ-005 bus_valid  input  1  register access request.
REQ-006 bus_ready  output  1  request accepted when bus_valid && bus_ready; held 1 outside reset.
REQ-007 bus_write  input  1  1 = write, 0 = read.
REQ-008 bus_address  input  8  byte address; bits [1:0] ignored.
REQ-009 bus_wdata  input  32  write data.
REQ-010 bus_rdata  output  32  read data, valid with bus_rvalid.
REQ-011 bus_rvalid  output  1  one-cycle read response strobe.
REQ-012 meip  output  1  machine external interrupt pending; drives the csr block's meip input.

Function
REQ-013 Register map SHALL be: 0x00 pending (RO); 0x04 enable (RW); 0x08 threshold [2:0] (RW); 0x0C claim/complete; 0x10 edge-select (RW, 1 = edge); 0x20+4*i priority[2:0] of source i (RW, i = 1..SOURCES).
REQ-014 Bitmask registers SHALL use bit i for source i; bit 0 and bits above SOURCES read 0 and ignore writes.
REQ-015 Each irq_src bit SHALL pass a 2-flop synchronizer before use; input-to-pending latency = 3 cycles.
REQ-016 Level mode: pending[i] SHALL set when the synchronized level is 1 and source i is not in-service; dropping the level SHALL NOT clear pending.
REQ-017 Edge mode: pending[i] SHALL set on a synchronized 0->1 transition regardless of in-service; edges while already pending are merged.
REQ-018 Source i is eligible when pending[i] && enable[i] && priority[i] > threshold.
REQ-019 meip SHALL be a register equal to "any source eligible", updated one cycle after the state it reflects.
REQ-020 Claim (read 0x0C) SHALL return the eligible ID with highest priority, ties to lowest ID, or 0 if none; the winner's pending is cleared and in-service set in the same cycle.
REQ-021 Complete (write 0x0C) SHALL clear in-service for ID bus_wdata[4:0]; IDs 0, > SOURCES or not in-service SHALL be ignored.
REQ-022 Claim and a pending-set for the same source in the same cycle: claim wins (pending 0, in-service 1); a level source is then blocked until complete.
REQ-023 Read data SHALL appear on bus_rdata with bus_rvalid=1 exactly one cycle after acceptance; back-to-back reads SHALL be accepted every cycle.
REQ-024 Unmapped reads SHALL return 0; unmapped and pending-register writes SHALL be ignored; writes produce no response.
REQ-025 Priority 0 or threshold 7 SHALL make the affected sources ineligible.

Reset
REQ-026 While reset=1: pending, in-service, enable, edge-select, all priorities, threshold, synchronizers and edge history SHALL clear; meip=0, bus_rvalid=0, bus_rdata=0, bus_ready=0.
REQ-027 Reset asserted mid-transaction SHALL drop the request without response; first access accepted the cycle after reset deasserts.

Verification
REQ-028 Level source 3, priority 2, enabled, threshold 0: raise irq_src[2] -> pending bit 3 at cycle 3, meip=1 at cycle 4; claim returns 3, meip=0 next cycle.
REQ-029 Sources 2 and 5 both priority 4, source 6 priority 4 disabled: claim -> 2, then 5, then 0.
REQ-030 Threshold 3, source 1 priority 3 pending -> meip=0; write priority 4 -> meip=1 two cycles later.
REQ-031 Edge source 4: two pulses before claim -> one claim returns 4, second claim returns 0; pulse after claim, before complete -> pending re-sets.
REQ-032 Level source 1 held high, claimed: pending stays 0 until complete(1), then re-sets next cycle; complete(0) and complete(9) ignored.
REQ-033 Assert reset with bus read outstanding and pending state set -> bus_rvalid=0, meip=0, all registers read 0 after reset.

Source files
------------

// File: rtl/interrupt_controller.sv
// ============================================================================
//  Module      : interrupt_controller
//  Description : Platform-level interrupt controller. Synchronises external
//                interrupt lines, tracks pending/in-service state per source,
//                arbitrates by priority against a threshold and raises meip.
//                Register access via a simple valid/ready bus with a
//                one-cycle read response; reading claim/complete claims the
//                winning source, writing it completes one.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_controller #(
    parameter int SOURCES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SOURCES-1:0]   irq_src,
    input  logic                 bus_valid,
    output logic                 bus_ready,
    input  logic                 bus_write,
    input  logic [7:0]           bus_address,
    input  logic [31:0]          bus_wdata,
    output logic [31:0]          bus_rdata,
    output logic                 bus_rvalid,
    output logic                 meip
);

    // Bit i of a source bitmask is source ID i; bit 0 and IDs above SOURCES
    // do not exist.
    localparam logic [31:0] c_SRC_MASK = ((32'd1 << SOURCES) - 32'd1) << 1;

    localparam logic [5:0] c_W_PENDING = 6'd0;
    localparam logic [5:0] c_W_ENABLE  = 6'd1;
    localparam logic [5:0] c_W_THRESH  = 6'd2;
    localparam logic [5:0] c_W_CLAIM   = 6'd3;
    localparam logic [5:0] c_W_EDGE    = 6'd4;

    // State, all source bitmasks kept ID-indexed in 32 bits
    logic [31:0] r_sync1;
    logic [31:0] r_sync2;
    logic [31:0] r_hist;
    logic [31:0] r_pend;
    logic [31:0] r_insvc;
    logic [31:0] r_en;
    logic [31:0] r_edge;
    logic [2:0]  r_thr;
    logic [2:0]  r_prio [1:SOURCES];
    logic        r_ready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_meip;

    // Combinational
    logic [31:0] w_irq;
    logic [5:0]  w_word;
    logic        w_rd;
    logic        w_wr;
    logic [31:0] w_set;
    logic [31:0] w_elig;
    logic [4:0]  w_win_id;
    logic [2:0]  w_win_prio;
    logic [31:0] w_claim_mask;
    logic [31:0] w_cmpl_mask;
    logic [31:0] w_rdata;
    logic        w_unused_ok;

    assign w_irq       = 32'({irq_src, 1'b0});
    assign w_word      = bus_address[7:2];
    assign w_rd        = bus_valid && r_ready && !bus_write;
    assign w_wr        = bus_valid && r_ready &&  bus_write;
    assign w_unused_ok = &{1'b0, bus_address[1:0]};

    // Level sources set while high and not in service; edge sources set on a
    // synchronised rising edge whatever their in-service state.
    assign w_set = ((r_sync2 & ~r_edge & ~r_insvc) |
                    (r_sync2 & ~r_hist & r_edge)) & c_SRC_MASK;

    assign w_claim_mask = (w_rd && (w_word == c_W_CLAIM)) ? (32'd1 << w_win_id) & c_SRC_MASK : 32'd0;
    assign w_cmpl_mask  = (w_wr && (w_word == c_W_CLAIM)) ? (32'd1 << bus_wdata[4:0]) & c_SRC_MASK : 32'd0;

    assign bus_ready  = r_ready;
    assign bus_rvalid = r_rvalid;
    assign bus_rdata  = r_rdata;
    assign meip       = r_meip;

    // Eligibility and arbitration: highest priority wins, ascending scan with
    // strict compare keeps ties on the lowest ID.
    always_comb begin
        w_elig     = 32'd0;
        w_win_id   = 5'd0;
        w_win_prio = 3'd0;
        for (int i = 1; i <= SOURCES; i++) begin
            if (r_pend[i] && r_en[i] && (r_prio[i] > r_thr)) begin
                w_elig[i] = 1'b1;
                if (r_prio[i] > w_win_prio) begin
                    w_win_prio = r_prio[i];
                    w_win_id   = 5'(i);
                end
            end
        end
    end

    // Read data mux; unmapped addresses return zero.
    always_comb begin
        w_rdata = 32'd0;
        case (w_word)
            c_W_PENDING: w_rdata = r_pend;
            c_W_ENABLE:  w_rdata = r_en;
            c_W_THRESH:  w_rdata = {29'd0, r_thr};
            c_W_CLAIM:   w_rdata = {27'd0, w_win_id};
            c_W_EDGE:    w_rdata = r_edge;
            default: begin
                for (int i = 1; i <= SOURCES; i++) begin
                    if (w_word == 6'(8 + i)) w_rdata = {29'd0, r_prio[i]};
                end
            end
        endcase
    end

    // Two-flop synchronisers plus one stage of history for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 32'd0;
            r_sync2 <= 32'd0;
            r_hist  <= 32'd0;
        end else begin
            r_sync1 <= w_irq;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Pending and in-service; a claim overrides a same-cycle pending set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend  <= 32'd0;
            r_insvc <= 32'd0;
        end else begin
            r_pend  <= (r_pend | w_set) & ~w_claim_mask;
            r_insvc <= (r_insvc | w_claim_mask) & ~w_cmpl_mask;
        end
    end

    // Configuration registers written over the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en   <= 32'd0;
            r_edge <= 32'd0;
            r_thr  <= 3'd0;
            for (int i = 1; i <= SOURCES; i++) r_prio[i] <= 3'd0;
        end else if (w_wr) begin
            case (w_word)
                c_W_ENABLE: r_en   <= bus_wdata & c_SRC_MASK;
                c_W_THRESH: r_thr  <= bus_wdata[2:0];
                c_W_EDGE:   r_edge <= bus_wdata & c_SRC_MASK;
                default: begin
                    for (int i = 1; i <= SOURCES; i++) begin
                        if (w_word == 6'(8 + i)) r_prio[i] <= bus_wdata[2:0];
                    end
                end
            endcase
        end
    end

    // Bus handshake and one-cycle read response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready  <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_ready  <= 1'b1;
            r_rvalid <= w_rd;
            r_rdata  <= w_rd ? w_rdata : 32'd0;
        end
    end

    // Registered interrupt request to the core.
    always_ff @(posedge clk) begin
        if (reset) r_meip <= 1'b0;
        else       r_meip <= |w_elig;
    end

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
//  Module      : tb_interrupt_controller
//  Description : Directed self-checking bench for interrupt_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

    localparam int SOURCES = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [SOURCES-1:0] irq_src;
    logic               bus_valid;
    logic               bus_ready;
    logic               bus_write;
    logic [7:0]         bus_address;
    logic [31:0]        bus_wdata;
    logic [31:0]        bus_rdata;
    logic               bus_rvalid;
    logic               meip;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    interrupt_controller #(.SOURCES(SOURCES)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_write  (bus_write),
        .bus_address(bus_address),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .meip       (meip)
    );

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("ready_timeout", {31'd0, bus_ready}, 32'd1);
    endtask

    task automatic bwr(input logic [7:0] a, input logic [31:0] d);
        bus_valid = 1'b1; bus_write = 1'b1; bus_address = a; bus_wdata = d;
        wait_ready();
        tick();
        bus_valid = 1'b0; bus_write = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        bus_valid = 1'b1; bus_write = 1'b0; bus_address = a;
        wait_ready();
        tick();
        bus_valid = 1'b0;
        chk({tag, "_rvalid"}, {31'd0, bus_rvalid}, 32'd1);
        chk(tag, bus_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; irq_src = '0; bus_valid = 1'b0; bus_write = 1'b0;
        bus_address = 8'd0; bus_wdata = 32'd0;

        // Reset state
        tick(3);
        chk("rst_ready",  {31'd0, bus_ready},  32'd0);
        chk("rst_rvalid", {31'd0, bus_rvalid}, 32'd0);
        chk("rst_rdata",  bus_rdata,           32'd0);
        chk("rst_meip",   {31'd0, meip},       32'd0);
        reset = 1'b0;
        tick();
        chk("ready_after_rst", {31'd0, bus_ready}, 32'd1);

        // Register map boundaries
        bwr(8'h04, 32'hFFFF_FFFF);
        rdchk("enable_mask", 8'h04, 32'h0000_01FE);
        bwr(8'h04, 32'd0);
        bwr(8'h00, 32'h0000_00FF);
        rdchk("pending_ro", 8'h00, 32'd0);
        rdchk("unmapped_14", 8'h14, 32'd0);
        rdchk("unmapped_20", 8'h20, 32'd0);
        bwr(8'h2C, 32'h0000_000F);
        rdchk("prio3_width", 8'h2C, 32'd7);

        // Level source 3: latency, meip, claim
        bwr(8'h2C, 32'd2);
        bwr(8'h04, 32'h08);
        irq_src[2] = 1'b1;
        tick(2);
        chk("l3_meip_c2", {31'd0, meip}, 32'd0);
        bus_valid = 1'b1; bus_write = 1'b0; bus_address = 8'h00;
        tick();
        chk("l3_pend_c3", bus_rdata, 32'd0);
        chk("l3_meip_c3", {31'd0, meip}, 32'd0);
        tick();
        chk("l3_b2b_rvalid", {31'd0, bus_rvalid}, 32'd1);
        chk("l3_pend_c4", bus_rdata, 32'h08);
        chk("l3_meip_c4", {31'd0, meip}, 32'd1);
        bus_address = 8'h0C;
        tick();
        chk("l3_claim", bus_rdata, 32'd3);
        bus_valid = 1'b0;
        tick();
        chk("l3_meip_after_claim", {31'd0, meip}, 32'd0);
        chk("l3_rvalid_drop", {31'd0, bus_rvalid}, 32'd0);
        irq_src[2] = 1'b0;
        tick(3);
        bwr(8'h0C, 32'd3);
        rdchk("l3_pend_clean", 8'h00, 32'd0);

        // Equal priorities tie to lowest ID; disabled source skipped
        bwr(8'h28, 32'd4);
        bwr(8'h34, 32'd4);
        bwr(8'h38, 32'd4);
        bwr(8'h04, 32'h24);
        irq_src = 8'b0011_0010;
        tick(4);
        bus_valid = 1'b1; bus_write = 1'b0; bus_address = 8'h0C;
        tick();
        chk("tie_claim_a", bus_rdata, 32'd2);
        tick();
        chk("tie_claim_b", bus_rdata, 32'd5);
        tick();
        chk("tie_claim_c", bus_rdata, 32'd0);
        bus_valid = 1'b0;
        irq_src[1] = 1'b0; irq_src[4] = 1'b0;
        tick(3);
        bwr(8'h0C, 32'd2);
        bwr(8'h0C, 32'd5);
        rdchk("tie_pend_left", 8'h00, 32'h40);

        // Threshold gating, priority raise takes effect on meip two cycles on
        bwr(8'h08, 32'd3);
        bwr(8'h24, 32'd3);
        bwr(8'h04, 32'h02);
        irq_src[0] = 1'b1;
        tick(5);
        chk("thr_meip_low", {31'd0, meip}, 32'd0);
        rdchk("thr_pend", 8'h00, 32'h42);
        bwr(8'h24, 32'd4);
        chk("thr_meip_c1", {31'd0, meip}, 32'd0);
        tick();
        chk("thr_meip_c2", {31'd0, meip}, 32'd1);

        // Held level source blocked while in service; bad completes ignored
        rdchk("hold_claim", 8'h0C, 32'd1);
        tick(3);
        rdchk("hold_pend_blocked", 8'h00, 32'h40);
        bwr(8'h0C, 32'd0);
        bwr(8'h0C, 32'd9);
        tick(2);
        rdchk("hold_bad_complete", 8'h00, 32'h40);
        bwr(8'h0C, 32'd1);
        rdchk("hold_pend_c1", 8'h00, 32'h40);
        rdchk("hold_pend_c2", 8'h00, 32'h42);
        rdchk("hold_reclaim", 8'h0C, 32'd1);
        irq_src[0] = 1'b0;
        tick(3);
        bwr(8'h0C, 32'd1);

        // Edge source 4: merged pulses, re-pend while in service
        bwr(8'h08, 32'd0);
        bwr(8'h10, 32'h10);
        bwr(8'h30, 32'd5);
        bwr(8'h04, 32'h10);
        rdchk("edge_sel_rd", 8'h10, 32'h10);
        irq_src[3] = 1'b1; tick(2); irq_src[3] = 1'b0; tick(2);
        irq_src[3] = 1'b1; tick(2); irq_src[3] = 1'b0; tick(4);
        rdchk("edge_pend", 8'h00, 32'h50);
        rdchk("edge_claim1", 8'h0C, 32'd4);
        rdchk("edge_claim2", 8'h0C, 32'd0);
        irq_src[3] = 1'b1; tick(2); irq_src[3] = 1'b0; tick(4);
        rdchk("edge_repend", 8'h00, 32'h50);
        rdchk("edge_claim3", 8'h0C, 32'd4);
        bwr(8'h0C, 32'd4);

        // Threshold 7 and priority 0 block eligibility
        bwr(8'h04, 32'h40);
        bwr(8'h08, 32'd7);
        tick(2);
        chk("thr7_meip", {31'd0, meip}, 32'd0);
        rdchk("thr7_claim", 8'h0C, 32'd0);
        bwr(8'h08, 32'd3);
        chk("thr3_meip_c1", {31'd0, meip}, 32'd0);
        tick();
        chk("thr3_meip_c2", {31'd0, meip}, 32'd1);
        bwr(8'h38, 32'd0);
        tick(2);
        chk("prio0_meip", {31'd0, meip}, 32'd0);
        rdchk("prio0_claim", 8'h0C, 32'd0);
        bwr(8'h38, 32'd4);
        tick(2);
        chk("prio4_meip", {31'd0, meip}, 32'd1);

        // Reset with a read outstanding and pending state set
        bus_valid = 1'b1; bus_write = 1'b0; bus_address = 8'h00;
        reset = 1'b1; irq_src = '0;
        tick();
        chk("mid_rst_rvalid", {31'd0, bus_rvalid}, 32'd0);
        chk("mid_rst_meip",   {31'd0, meip},       32'd0);
        chk("mid_rst_ready",  {31'd0, bus_ready},  32'd0);
        tick();
        reset = 1'b0; bus_valid = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, bus_ready}, 32'd1);
        rdchk("post_pend",  8'h00, 32'd0);
        rdchk("post_en",    8'h04, 32'd0);
        rdchk("post_thr",   8'h08, 32'd0);
        rdchk("post_edge",  8'h10, 32'd0);
        rdchk("post_prio6", 8'h38, 32'd0);
        rdchk("post_claim", 8'h0C, 32'd0);
        chk("post_meip", {31'd0, meip}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
